// File: rtl/id_hazard_controller_pkg.sv
// Shared opcode constants, FSM state encoding and field-width defaults for the
// ID-stage hazard controller and its register-use decoder.
package id_hazard_controller_pkg;

    localparam int NB_REG_DEF    = 5;
    localparam int NB_OPCODE_DEF = 6;

    localparam logic [NB_OPCODE_DEF-1:0] OP_RTYPE = 6'b000000;
    localparam logic [NB_OPCODE_DEF-1:0] OP_J     = 6'b000010;
    localparam logic [NB_OPCODE_DEF-1:0] OP_JAL   = 6'b000011;
    localparam logic [NB_OPCODE_DEF-1:0] OP_LUI   = 6'b001111;
    localparam logic [NB_OPCODE_DEF-1:0] OP_BEQ   = 6'b000100;
    localparam logic [NB_OPCODE_DEF-1:0] OP_BNE   = 6'b000101;
    localparam logic [NB_OPCODE_DEF-1:0] OP_SB    = 6'b101000;
    localparam logic [NB_OPCODE_DEF-1:0] OP_SH    = 6'b101001;
    localparam logic [NB_OPCODE_DEF-1:0] OP_SW    = 6'b101011;
    localparam logic [NB_OPCODE_DEF-1:0] OP_HALT  = 6'b111111;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_STEP     = 2'd1,
        ST_DBG_HALT = 2'd2,
        ST_END      = 2'd3
    } state_e;

endpackage

// File: rtl/id_reg_use_decode.sv
// Combinational opcode decode telling the hazard logic whether the instruction
// in ID actually reads its rs and/or rt register fields.
module id_reg_use_decode
    import id_hazard_controller_pkg::*;
#(
    parameter int NB_OPCODE = NB_OPCODE_DEF
) (
    input  logic [NB_OPCODE-1:0] i_opcode,
    output logic                 o_uses_rs,
    output logic                 o_uses_rt
);

    always_comb begin
        o_uses_rs = 1'b1;
        o_uses_rt = 1'b0;
        case (i_opcode)
            NB_OPCODE'(OP_J),
            NB_OPCODE'(OP_JAL),
            NB_OPCODE'(OP_LUI):   o_uses_rs = 1'b0;
            NB_OPCODE'(OP_RTYPE),
            NB_OPCODE'(OP_BEQ),
            NB_OPCODE'(OP_BNE),
            NB_OPCODE'(OP_SB),
            NB_OPCODE'(OP_SH),
            NB_OPCODE'(OP_SW):    o_uses_rt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/id_hazard_controller.sv
// Fetch/decode sequencer: load-use stall, branch/jump flush, debug halt/step and
// program HALT. Define ID_HAZARD_STALL_CNT_EN to build the stall-cycle counter.
module id_hazard_controller
    import id_hazard_controller_pkg::*;
#(
    parameter int NB_REG    = NB_REG_DEF,
    parameter int NB_OPCODE = NB_OPCODE_DEF,
    parameter int NB_CNT    = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NB_OPCODE-1:0] i_opcode,
    input  logic [NB_REG-1:0]    i_rs,
    input  logic [NB_REG-1:0]    i_rt,
    input  logic                 i_ex_mem_read,
    input  logic [NB_REG-1:0]    i_ex_rt,
    input  logic                 i_branch_taken,
    input  logic                 i_jump,
    input  logic                 i_halt_req,
    input  logic                 i_step,
    output logic                 o_pc_write,
    output logic                 o_ifid_write,
    output logic                 o_ifid_flush,
    output logic                 o_ctrl_bubble,
    output logic                 o_halted,
    output logic                 o_dbg_halted,
    output logic [NB_CNT-1:0]    o_stall_count
);

    state_e state_q, state_d;
    logic   uses_rs, uses_rt;
    logic   flush, load_use, is_halt_op, active, take_halt;

    id_reg_use_decode #(
        .NB_OPCODE (NB_OPCODE)
    ) u_reg_use (
        .i_opcode  (i_opcode),
        .o_uses_rs (uses_rs),
        .o_uses_rt (uses_rt)
    );

    assign flush      = i_branch_taken | i_jump;
    assign load_use   = i_ex_mem_read && (i_ex_rt != '0) &&
                        ((uses_rs && (i_rs == i_ex_rt)) || (uses_rt && (i_rt == i_ex_rt)));
    assign is_halt_op = (i_opcode == NB_OPCODE'(OP_HALT));
    assign active     = (state_q == ST_RUN) || (state_q == ST_STEP);
    // A redirect or a stall pre-empts HALT decode; the HALT is seen again later.
    assign take_halt  = active && !flush && !load_use && is_halt_op;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        o_pc_write    = 1'b0;
        o_ifid_write  = 1'b0;
        o_ifid_flush  = 1'b0;
        o_ctrl_bubble = 1'b1;
        o_halted      = 1'b0;
        o_dbg_halted  = 1'b0;
        if (i_reset) begin
            o_ifid_flush = 1'b1;
            state_d      = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN, ST_STEP: begin
                    if (flush) begin
                        o_pc_write   = 1'b1;
                        o_ifid_write = 1'b1;
                        o_ifid_flush = 1'b1;
                    end else if (!load_use && !is_halt_op) begin
                        o_pc_write    = 1'b1;
                        o_ifid_write  = 1'b1;
                        o_ctrl_bubble = 1'b0;
                    end
                    if (take_halt) begin
                        state_d = ST_END;
                    end else if ((state_q == ST_STEP) || i_halt_req) begin
                        state_d = ST_DBG_HALT;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_DBG_HALT: begin
                    o_dbg_halted = 1'b1;
                    if (i_step) begin
                        state_d = ST_STEP;
                    end else if (!i_halt_req) begin
                        state_d = ST_RUN;
                    end
                end
                ST_END: begin
                    o_halted = 1'b1;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

`ifdef ID_HAZARD_STALL_CNT_EN
    logic              stall_inc;
    logic [NB_CNT-1:0] stall_cnt_q, stall_cnt_d;

    assign stall_inc = active && !flush && load_use;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_inc && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + NB_CNT'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_stall_count = stall_cnt_q;
`else
    assign o_stall_count = '0;
`endif

endmodule

// File: tb/tb_id_hazard_controller.sv
// Bench for id_hazard_controller: directed scenarios then random traffic, all
// checked every cycle against a flag-based reference model.
module tb_id_hazard_controller;

    localparam int NB_REG    = 5;
    localparam int NB_OPCODE = 6;
    localparam int NB_CNT    = 4;
    localparam int CNT_MAX   = (1 << NB_CNT) - 1;
`ifdef ID_HAZARD_STALL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NB_OPCODE-1:0] op;
    logic [NB_REG-1:0]    rs, rt, ex_rt;
    logic                 exr, br, jmp, hreq, stp;
    logic                 pc_w, ifid_w, ifid_fl, bub, halted, dbg_halted;
    logic [NB_CNT-1:0]    stall_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model state
    bit m_end  = 1'b0;
    bit m_dbg  = 1'b0;
    bit m_step = 1'b0;
    int m_cnt  = 0;

    always #5 clk = ~clk;

    id_hazard_controller #(
        .NB_REG    (NB_REG),
        .NB_OPCODE (NB_OPCODE),
        .NB_CNT    (NB_CNT)
    ) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_opcode       (op),
        .i_rs           (rs),
        .i_rt           (rt),
        .i_ex_mem_read  (exr),
        .i_ex_rt        (ex_rt),
        .i_branch_taken (br),
        .i_jump         (jmp),
        .i_halt_req     (hreq),
        .i_step         (stp),
        .o_pc_write     (pc_w),
        .o_ifid_write   (ifid_w),
        .o_ifid_flush   (ifid_fl),
        .o_ctrl_bubble  (bub),
        .o_halted       (halted),
        .o_dbg_halted   (dbg_halted),
        .o_stall_count  (stall_cnt)
    );

    function automatic bit f_uses_rs(input logic [5:0] o);
        return !(o inside {6'd2, 6'd3, 6'd15});
    endfunction

    function automatic bit f_uses_rt(input logic [5:0] o);
        return o inside {6'd0, 6'd4, 6'd5, 6'd40, 6'd41, 6'd43};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit r, input logic [5:0] o, input logic [4:0] s, input logic [4:0] t,
                         input bit mr, input logic [4:0] et, input bit b, input bit jj,
                         input bit h, input bit st);
        rst = r; op = o; rs = s; rt = t; exr = mr; ex_rt = et;
        br = b; jmp = jj; hreq = h; stp = st;
    endtask

    task automatic cycle(input string tag);
        bit lu, fl, hop, running, ck_ifw;
        logic e_pc, e_ifw, e_fl, e_bub, e_h, e_dh;
        @(negedge clk);
        lu  = exr && (ex_rt != 0) &&
              ((f_uses_rs(op) && rs == ex_rt) || (f_uses_rt(op) && rt == ex_rt));
        fl  = br || jmp;
        hop = (op == 6'd63);
        running = !rst && !m_end && !m_dbg;
        ck_ifw = 1'b1;
        e_h = 0; e_dh = 0;
        if (rst) begin
            e_pc = 0; e_ifw = 0; e_fl = 1; e_bub = 1;
        end else if (m_end) begin
            e_pc = 0; e_ifw = 0; e_fl = 0; e_bub = 1; e_h = 1;
        end else if (m_dbg) begin
            e_pc = 0; e_ifw = 0; e_fl = 0; e_bub = 1; e_dh = 1;
        end else if (fl) begin
            e_pc = 1; e_ifw = 0; e_fl = 1; e_bub = 1; ck_ifw = 0;
        end else if (lu || hop) begin
            e_pc = 0; e_ifw = 0; e_fl = 0; e_bub = 1;
        end else begin
            e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 0;
        end
        chk({tag, ".pc_write"}, 32'(pc_w), 32'(e_pc));
        if (ck_ifw) chk({tag, ".ifid_write"}, 32'(ifid_w), 32'(e_ifw));
        chk({tag, ".ifid_flush"}, 32'(ifid_fl), 32'(e_fl));
        chk({tag, ".ctrl_bubble"}, 32'(bub), 32'(e_bub));
        chk({tag, ".halted"}, 32'(halted), 32'(e_h));
        chk({tag, ".dbg_halted"}, 32'(dbg_halted), 32'(e_dh));
        chk({tag, ".stall_count"}, 32'(stall_cnt), CNT_EN ? 32'(m_cnt) : 32'd0);
        if (rst) begin
            m_end = 0; m_dbg = 0; m_step = 0; m_cnt = 0;
        end else if (m_dbg) begin
            if (stp) begin
                m_dbg = 0; m_step = 1;
            end else if (!hreq) begin
                m_dbg = 0;
            end
        end else if (running) begin
            if (!fl && lu && m_cnt < CNT_MAX) m_cnt++;
            if (!fl && !lu && hop) begin
                m_end = 1; m_step = 0;
            end else if (m_step) begin
                m_step = 0; m_dbg = 1;
            end else if (hreq) begin
                m_dbg = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    logic [5:0] ops [12] = '{6'd0, 6'd2, 6'd3, 6'd15, 6'd4, 6'd5,
                             6'd40, 6'd41, 6'd43, 6'd35, 6'd8, 6'd13};

    initial begin
        logic [5:0] r_op;
        bit r_rst, r_h;
        r_h = 0;
        // reset
        drive(1, 6'd0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
        cycle("reset0");
        cycle("reset1");
        // load-use on rs: LW rt=5 in EX, ADD rs=5 rt=3 in ID
        drive(0, 6'd0, 5'd5, 5'd3, 1, 5'd5, 0, 0, 0, 0);
        cycle("lu_rs_stall");
        drive(0, 6'd0, 5'd5, 5'd3, 0, 5'd5, 0, 0, 0, 0);
        cycle("lu_rs_resume");
        // no false hazards
        drive(0, 6'd0, 5'd0, 5'd0, 1, 5'd0, 0, 0, 0, 0);
        cycle("no_haz_r0");
        drive(0, 6'd2, 5'd4, 5'd0, 1, 5'd4, 0, 0, 0, 0);
        cycle("no_haz_j");
        // flush has priority over a load-use hazard
        drive(0, 6'd0, 5'd7, 5'd1, 1, 5'd7, 1, 0, 0, 0);
        cycle("flush_over_lu");
        // debug halt, single step, resume
        drive(0, 6'd0, 5'd1, 5'd2, 0, 5'd0, 0, 0, 1, 0);
        cycle("dbg_req");
        cycle("dbg_frozen");
        drive(0, 6'd0, 5'd1, 5'd2, 0, 5'd0, 0, 0, 1, 1);
        cycle("dbg_step_pulse");
        drive(0, 6'd0, 5'd1, 5'd2, 0, 5'd0, 0, 0, 1, 0);
        cycle("dbg_step_exec");
        cycle("dbg_refrozen");
        drive(0, 6'd0, 5'd1, 5'd2, 0, 5'd0, 0, 0, 0, 0);
        cycle("dbg_release");
        cycle("dbg_run");
        // HALT opcode: sticky until reset
        drive(0, 6'd63, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
        cycle("halt_decode");
        drive(0, 6'd0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 1);
        cycle("halt_ign_step");
        drive(0, 6'd0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
        cycle("halt_sticky");
        drive(1, 6'd0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
        cycle("halt_reset");
        drive(0, 6'd0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
        cycle("post_reset_run");
        // counter saturation with 17 stall cycles
        drive(0, 6'd43, 5'd2, 5'd9, 1, 5'd9, 0, 0, 0, 0);
        for (int i = 0; i < 17; i++) cycle("sat_stall");
        drive(0, 6'd0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
        cycle("sat_hold");
        // mid-stall reset clears counter
        drive(1, 6'd0, 5'd3, 5'd0, 1, 5'd3, 0, 0, 0, 0);
        cycle("reset_mid_stall");
        drive(0, 6'd0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
        cycle("after_mid_reset");
        // random traffic
        for (int i = 0; i < 800; i++) begin
            r_op  = ($urandom_range(0, 99) < 4) ? 6'd63 : ops[$urandom_range(0, 11)];
            r_rst = m_end ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 9) == 0) r_h = !r_h;
            drive(r_rst, r_op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
                  r_h, $urandom_range(0, 3) == 0);
            cycle("rand");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
